arb8_rr: RTL
============

Name: arb8_rr

Overview:
- 8-requester round-robin arbiter that shares one 32-bit resource port, such as the unified memory port, between pipeline clients.
- Produces the 3-bit select for the downstream mux8 on the request datapath, plus a one-hot grant and a start level to the resource.
- Holds each grant until the resource responds, the requester withdraws, or a hold timeout fires.

Parameters:
- HOLD_LIMIT, 64: maximum cycles a grant may stay open without mem_resp. 0 disables the timeout.
- CNT_W, $clog2(HOLD_LIMIT+1) with a minimum of 1: width of the hold counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request level per client; bit k = client k.
- mem_resp  input  1  resource done; 1-cycle pulse from the resource.
- grant  output  8  one-hot registered grant; all zero when idle.
- sel  output  3  binary index of the granted client; drives mux8 sel.
- mem_start  output  1  high for every cycle a grant is open.
- busy  output  1  equals the GRANT state.
- timeout  output  1  1-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, grant=0, sel=0, mem_start=0, busy=0, timeout=0, hold count=0.
  - last_ptr=7, so client 0 has highest priority after reset.
  - Reset asserted mid-grant forces all of the above immediately. No response is tracked across reset.
- States: IDLE, GRANT. All outputs are registered; no combinational path from req to grant.
- IDLE:
  - If req != 0, pick the first set bit scanning last_ptr+1, last_ptr+2, … modulo 8 (wrap 7→0).
  - Next edge: state=GRANT, grant=onehot(pick), sel=pick, mem_start=1, busy=1, count=0.
  - Latency: req seen before edge n gives grant visible after edge n.
  - mem_resp in IDLE is ignored.
- GRANT:
  - grant and sel are held stable. Other req bits are ignored. count increments each cycle and saturates.
  - Release conditions are evaluated in priority order:
    - (1) mem_resp=1: normal completion.
    - (2) req[sel]=0: requester abort. The resource must tolerate mem_start dropping.
    - (3) HOLD_LIMIT!=0 and count==HOLD_LIMIT-1: timeout, with timeout=1 for the following cycle only.
  - On release, next edge: state=IDLE, grant=0, mem_start=0, busy=0, last_ptr=sel. sel keeps its last value.
- Turnaround: at least one IDLE cycle between consecutive grants. This is a fixed 1-cycle bubble and is intentional, so the resource sees mem_start low between transactions.
- Simultaneous events:
  - mem_resp and timeout condition in the same cycle: completion wins, no timeout pulse.
  - mem_resp and abort in the same cycle: completion.
- Fairness: a client continuously requesting waits at most 7 other grants.
- Invariants: grant is always one-hot or zero, and grant==0 iff busy==0.

Decomposition:
- Shared package arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  - localparam NUM_REQ=8;
  - localparam SEL_W=3.
- One sub-module, rr_pick8 (combinational):
  - inputs req[7:0], last_ptr[2:0]; outputs valid, idx[2:0].
  - Implemented as a rotate, priority-encode, un-rotate.
  - Unit-testable exhaustively (2^11 cases).

Test Plan:
- Reset then req=8'b0000_0001 at cycle 2 → grant=01, sel=0, mem_start=1 after the next edge; mem_resp at cycle 5 → grant=00 after the next edge; last_ptr=0.
- req=8'hFF held, mem_resp pulsed 2 cycles after each grant → grant sequence 0,1,2,…,7,0, each separated by exactly one IDLE cycle; no client skipped.
- last_ptr=5, req=8'b0010_0001 → client 0 granted (wrap past 7); then req=8'b0010_0001 again → client 5.
- HOLD_LIMIT=4, grant to client 3, no mem_resp → release after 4 GRANT cycles; timeout high for exactly 1 cycle; mem_resp on the same cycle as the limit → no timeout.
- Granted client 2 drops req mid-grant → grant=0 next edge, no timeout, next arbitration starts from client 3.
- rst_n pulsed low while in GRANT with sel=6 → all outputs zero asynchronously; after release, req=8'hFF grants client 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter and its picker.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Round-robin pick: rotate so the slot after last_ptr sits at bit 0, take the
// lowest set bit, then rotate the index back into client numbering.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0]     start;
  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [SEL_W-1:0]     offset;

  // start wraps 7 -> 0 through the 3-bit add
  assign start   = last_ptr + 3'd1;
  assign doubled = {req, req} >> start;
  assign rotated = doubled[NUM_REQ-1:0];
  assign valid   = |req;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = SEL_W'(i);
    end
  end

  assign idx = start + offset;

endmodule : rr_pick8

// File: rtl/arb8_rr.sv
// 8-requester round-robin arbiter for a shared resource port. Grants are held
// until completion, requester abort or hold timeout, with a 1-cycle idle bubble.
module arb8_rr
  import arb_pkg::*;
#(
  parameter int HOLD_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mem_resp,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               mem_start,
  output logic               busy,
  output logic               timeout
);

  localparam int CNT_W_RAW = $clog2(HOLD_LIMIT + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] count;
  logic [SEL_W-1:0] last_ptr;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_expired;
  logic             release_now;

  rr_pick8 u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign hold_expired = (HOLD_LIMIT != 0) && (count == CNT_LAST);
  assign release_now  = mem_resp || !req[sel] || hold_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      sel       <= '0;
      mem_start <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      count     <= '0;
      last_ptr  <= 3'd7;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state     <= ARB_GRANT;
            grant     <= NUM_REQ'(1) << pick_idx;
            sel       <= pick_idx;
            mem_start <= 1'b1;
            busy      <= 1'b1;
            count     <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            mem_start <= 1'b0;
            busy      <= 1'b0;
            last_ptr  <= sel;
            // pulse only when the limit is the sole reason for release
            timeout   <= !mem_resp && req[sel] && hold_expired;
          end else if (count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule : arb8_rr
